button_input: RTL and testbench

Front end of the 2048 move path: it conditions four raw, asynchronous push-buttons into clean move commands for the game logic. Each input is synchronised and debounced, and only press edges are detected. Presses are arbitrated to a single direction, emitted as a one-cycle pulse, and followed by a lockout window so the game logic can finish its tile insertion before the next move. Outputs connect directly to the game logic's `btn_up`/`btn_right`/`btn_down`/`btn_left` inputs.

---
 rtl/button_input_if.sv | 23 ++
 rtl/button_input.sv | 111 +++++++++++
 tb/tb_button_input.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/button_input_if.sv
// Bundle of raw button inputs and conditioned move outputs between the
// button front end (slave) and whatever drives the buttons / consumes moves (master).
interface button_input_if;
   logic btn_up_raw;
   logic btn_right_raw;
   logic btn_down_raw;
   logic btn_left_raw;
   logic btn_up;
   logic btn_right;
   logic btn_down;
   logic btn_left;
   logic busy;

   modport master (
      output btn_up_raw, btn_right_raw, btn_down_raw, btn_left_raw,
      input  btn_up, btn_right, btn_down, btn_left, busy
   );

   modport slave (
      input  btn_up_raw, btn_right_raw, btn_down_raw, btn_left_raw,
      output btn_up, btn_right, btn_down, btn_left, busy
   );
endinterface

// File: rtl/button_input.sv
// Conditions four raw push-buttons into single-cycle, arbitrated move pulses
// followed by a lockout window for the 2048 game logic.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a debounced press edge
// LOCK  | move pulse issued; dropping presses until lockout expires
module button_input #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   button_input_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_LOCK = 1'b1;

   // bit 3 = up, 2 = right, 1 = down, 0 = left
   logic [3:0]    raw;
   logic [3:0]    meta;
   logic [3:0]    sync;
   logic [3:0]    stable;
   logic [3:0]    stable_d;
   logic [DW-1:0] deb_cnt [4];
   logic [3:0]    press;
   logic [3:0]    win;
   logic [3:0]    move;
   logic [0:0]    state;
   logic [LW-1:0] lock_cnt;

   assign raw = {bus.btn_up_raw, bus.btn_right_raw, bus.btn_down_raw, bus.btn_left_raw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // stable only follows sync after DEBOUNCE_CYCLES consecutive disagreeing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         stable_d <= stable;
         for (int i = 0; i < 4; i++) begin
            if (sync[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press = stable & ~stable_d;

   always_comb begin
      win = 4'b0000;
      if (press[3])      win = 4'b1000;
      else if (press[2]) win = 4'b0100;
      else if (press[1]) win = 4'b0010;
      else if (press[0]) win = 4'b0001;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= STATE_IDLE;
         lock_cnt <= '0;
         move     <= '0;
      end else begin
         move <= '0;
         case (state)
            STATE_IDLE: begin
               if (|press) begin
                  move     <= win;
                  lock_cnt <= LOCK_LOAD;
                  state    <= STATE_LOCK;
               end
            end
            STATE_LOCK: begin
               if (lock_cnt == '0) state <= STATE_IDLE;
               else                lock_cnt <= lock_cnt - 1'b1;
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

   assign bus.btn_up    = move[3];
   assign bus.btn_right = move[2];
   assign bus.btn_down  = move[1];
   assign bus.btn_left  = move[0];
   assign bus.busy      = (state == STATE_LOCK);

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input (D=4, L=8): expected pulses are queued when
// buttons are driven and matched by a monitor when the DUT emits them.
module tb_button_input;

   localparam logic [3:0] UP    = 4'b1000;
   localparam logic [3:0] RIGHT = 4'b0100;
   localparam logic [3:0] DOWN  = 4'b0010;
   localparam logic [3:0] LEFT  = 4'b0001;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n;
   int   m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_input_if bus();

   button_input #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] dir;
      int         at;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [3:0] mv;
   assign mv = {bus.btn_up, bus.btn_right, bus.btn_down, bus.btn_left};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic expect_pulse(input logic [3:0] dir, input int at);
      exp_t e;
      e.dir = dir;
      e.at  = at;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mv !== 4'b0000) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {28'd0, mv}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_dir", {28'd0, mv}, {28'd0, e.dir});
            check("pulse_cycle", cyc, e.at);
            check("busy_with_pulse", {31'd0, bus.busy}, 32'd1);
         end
      end
   end

   initial begin
      rst_n             = 1'b0;
      bus.btn_up_raw    = 1'b0;
      bus.btn_right_raw = 1'b0;
      bus.btn_down_raw  = 1'b0;
      bus.btn_left_raw  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_moves", {28'd0, mv}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      goto(cyc + 4);

      // clean press on left, held afterwards
      n = cyc;
      bus.btn_left_raw = 1'b1;
      expect_pulse(LEFT, n + 7);
      goto(n + 6);  check("clean_busy_pre", {31'd0, bus.busy}, 32'd0);
      goto(n + 7);  check("clean_busy_rise", {31'd0, bus.busy}, 32'd1);
      goto(n + 14); check("clean_busy_last", {31'd0, bus.busy}, 32'd1);
      goto(n + 15); check("clean_busy_fall", {31'd0, bus.busy}, 32'd0);
      goto(n + 35);
      bus.btn_left_raw = 1'b0;
      goto(n + 45);

      // glitch of 3 cycles rejected
      n = cyc;
      bus.btn_up_raw = 1'b1;
      goto(n + 3);
      bus.btn_up_raw = 1'b0;
      goto(n + 7);  check("glitch_busy_a", {31'd0, bus.busy}, 32'd0);
      goto(n + 12); check("glitch_busy_b", {31'd0, bus.busy}, 32'd0);

      // 4 cycles high is accepted
      n = cyc;
      bus.btn_up_raw = 1'b1;
      expect_pulse(UP, n + 7);
      goto(n + 4);
      bus.btn_up_raw = 1'b0;
      goto(n + 7);  check("min_press_busy", {31'd0, bus.busy}, 32'd1);
      goto(n + 25);

      // simultaneous right + down: right wins, down never emitted
      n = cyc;
      bus.btn_right_raw = 1'b1;
      bus.btn_down_raw  = 1'b1;
      expect_pulse(RIGHT, n + 7);
      goto(n + 35);
      check("simul_busy_after", {31'd0, bus.busy}, 32'd0);
      bus.btn_right_raw = 1'b0;
      bus.btn_down_raw  = 1'b0;
      goto(n + 45);

      // left pressed during lockout is dropped; later left press accepted
      n = cyc;
      bus.btn_up_raw = 1'b1;
      expect_pulse(UP, n + 7);
      goto(n + 2);
      bus.btn_left_raw = 1'b1;
      goto(n + 5);
      bus.btn_up_raw = 1'b0;
      goto(n + 9);  check("lock_busy_mid", {31'd0, bus.busy}, 32'd1);
      bus.btn_left_raw = 1'b0;
      goto(n + 20);
      bus.btn_left_raw = 1'b1;
      expect_pulse(LEFT, n + 27);
      goto(n + 26);
      bus.btn_left_raw = 1'b0;
      goto(n + 45);

      // reset while the pulse is high, up held through reset release
      n = cyc;
      bus.btn_up_raw = 1'b1;
      expect_pulse(UP, n + 7);
      goto(n + 7);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_moves", {28'd0, mv}, 32'd0);
      check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      goto(n + 10);
      rst_n = 1'b1;
      m = cyc;
      expect_pulse(UP, m + 7);
      goto(m + 6);  check("post_rst_busy_pre", {31'd0, bus.busy}, 32'd0);
      goto(m + 7);  check("post_rst_busy_rise", {31'd0, bus.busy}, 32'd1);
      goto(m + 20);
      bus.btn_up_raw = 1'b0;
      goto(m + 30);

      // release >= D then re-press after lockout: two pulses
      n = cyc;
      bus.btn_right_raw = 1'b1;
      expect_pulse(RIGHT, n + 7);
      goto(n + 6);
      bus.btn_right_raw = 1'b0;
      goto(n + 12);
      bus.btn_right_raw = 1'b1;
      expect_pulse(RIGHT, n + 19);
      goto(n + 25);
      bus.btn_right_raw = 1'b0;
      goto(n + 40);

      // release < D: bounce is absorbed, only one pulse
      n = cyc;
      bus.btn_right_raw = 1'b1;
      expect_pulse(RIGHT, n + 7);
      goto(n + 6);
      bus.btn_right_raw = 1'b0;
      goto(n + 8);
      bus.btn_right_raw = 1'b1;
      goto(n + 20); check("bounce_busy_after", {31'd0, bus.busy}, 32'd0);
      goto(n + 30);
      bus.btn_right_raw = 1'b0;
      goto(n + 45);

      check("pending_pulses", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
